// File: rtl/instr_mem_loadable.sv
// Byte-addressed instruction memory with a serial program loader and a
// registered, big-endian 32-bit fetch port.
//
// Handshakes:
//   Fetch: a request is taken on a rising edge when fetch_req && fetch_ready.
//          Its result (instr_code / instr_fault, qualified by instr_valid) is
//          visible for exactly the one cycle after that edge. While fetch_ready
//          is low (LOAD) requests are dropped, so the PC stage must hold PC.
//   Load:  a byte is taken on a rising edge when ld_valid && ld_ready and
//          ld_start is low. ld_start restarts the image at byte 0 and wins
//          over a coincident ld_valid.
//
// The current FSM state is exported on fsm_state (0 IDLE, 1 LOAD, 2 RUN).
module instr_mem_loadable #(
    parameter int DEPTH_BYTES = 256,
    parameter int PC_W        = 32,
    parameter int CNT_W       = $clog2(DEPTH_BYTES) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PC_W-1:0]  PC,
    input  logic             fetch_req,
    output logic             fetch_ready,
    output logic [31:0]      instr_code,
    output logic             instr_valid,
    output logic             instr_fault,
    input  logic             ld_start,
    input  logic             ld_valid,
    input  logic [7:0]       ld_byte,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic [CNT_W-1:0] ld_count,
    output logic             loaded,
    output logic [1:0]       fsm_state
);

    // Byte-address width of the array.
    localparam int AW = $clog2(DEPTH_BYTES);

    // Highest PC that still has four bytes of memory behind it.
    localparam logic [PC_W-1:0]  LAST_WORD_PC = PC_W'(DEPTH_BYTES - 4);
    // Address of the final byte; a write here completes the image.
    localparam logic [CNT_W-1:0] LAST_BYTE    = CNT_W'(DEPTH_BYTES - 1);
    // Saturation value of the load counter.
    localparam logic [CNT_W-1:0] FULL_COUNT   = CNT_W'(DEPTH_BYTES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [7:0] mem [DEPTH_BYTES];

    logic          fetch_accept;
    logic          fetch_fault;
    logic [31:0]   fetch_word;
    logic [AW-3:0] fetch_word_addr;
    logic          load_write;
    logic          load_done;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------

    // Fetch acceptance, fault detection and the big-endian word read.
    always_comb begin
        fetch_accept    = fetch_req && fetch_ready;
        fetch_fault     = (PC[1:0] != 2'b00) || (PC > LAST_WORD_PC);
        // Only meaningful when there is no fault; then PC < DEPTH_BYTES.
        fetch_word_addr = PC[AW-1:2];
        fetch_word      = {mem[{fetch_word_addr, 2'b00}],
                           mem[{fetch_word_addr, 2'b01}],
                           mem[{fetch_word_addr, 2'b10}],
                           mem[{fetch_word_addr, 2'b11}]};
    end

    // A byte is written only in LOAD, and a restart in the same cycle drops it.
    always_comb begin
        load_write = (state == S_LOAD) && ld_valid && !ld_start;
        load_done  = load_write && (ld_last || (ld_count == LAST_BYTE));
    end

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: ld_start always (re)enters LOAD; the image ends on
    // ld_last or on a write to the final byte.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_RUN: begin
                if (ld_start) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (ld_start) begin
                    state_next = S_LOAD;
                end else if (load_done) begin
                    state_next = S_RUN;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        fetch_ready = (state != S_LOAD);
        ld_ready    = (state == S_LOAD);
        loaded      = (state == S_RUN);
        fsm_state   = state;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Memory array: cleared on reset, written one byte per accepted load beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem[AW'(i)] <= 8'h00;
            end
        end else if (load_write) begin
            mem[ld_count[AW-1:0]] <= ld_byte;
        end
    end

    // Load counter: cleared on every (re)start, saturates at DEPTH_BYTES.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_count <= '0;
        end else if (ld_start) begin
            ld_count <= '0;
        end else if (load_write && (ld_count != FULL_COUNT)) begin
            ld_count <= ld_count + CNT_W'(1);
        end
    end

    // Fetch result register: word or NOP on fault; code holds when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_code  <= 32'h0000_0000;
            instr_valid <= 1'b0;
            instr_fault <= 1'b0;
        end else if (fetch_accept) begin
            instr_code  <= fetch_fault ? 32'h0000_0000 : fetch_word;
            instr_valid <= 1'b1;
            instr_fault <= fetch_fault;
        end else begin
            instr_valid <= 1'b0;
            instr_fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench for instr_mem_loadable: a table of fetch vectors against a
// loaded image, plus hand-written sequences for load, stall, restart and reset.
module tb_instr_mem_loadable;

    localparam int DEPTH_BYTES = 256;
    localparam int PC_W        = 32;
    localparam int CNT_W       = $clog2(DEPTH_BYTES) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [PC_W-1:0]  pc;
    logic             fetch_req;
    logic             fetch_ready;
    logic [31:0]      instr_code;
    logic             instr_valid;
    logic             instr_fault;
    logic             ld_start;
    logic             ld_valid;
    logic [7:0]       ld_byte;
    logic             ld_last;
    logic             ld_ready;
    logic [CNT_W-1:0] ld_count;
    logic             loaded;
    logic [1:0]       fsm_state;

    instr_mem_loadable #(
        .DEPTH_BYTES(DEPTH_BYTES),
        .PC_W       (PC_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PC         (pc),
        .fetch_req  (fetch_req),
        .fetch_ready(fetch_ready),
        .instr_code (instr_code),
        .instr_valid(instr_valid),
        .instr_fault(instr_fault),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_byte    (ld_byte),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .ld_count   (ld_count),
        .loaded     (loaded),
        .fsm_state  (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] code;
        logic        fault;
    } fetch_vec_t;

    fetch_vec_t vecs[14];
    logic [7:0] load_buf[DEPTH_BYTES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        fetch_req = 1'b0;
        pc        = '0;
        ld_start  = 1'b0;
        ld_valid  = 1'b0;
        ld_byte   = 8'h00;
        ld_last   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    // Stream load_buf[0..n-1]; ld_last on the final byte when use_last.
    task automatic send_bytes(input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_byte  = load_buf[i];
            ld_last  = use_last && (i == n - 1);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Single fetch, checks the registered result one edge later.
    task automatic fetch_check(input string name, input logic [31:0] addr,
                               input logic [31:0] exp_code, input logic exp_fault);
        pc        = addr;
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        check({name, " valid"}, 32'(instr_valid), 32'd1);
        check({name, " fault"}, 32'(instr_fault), 32'(exp_fault));
        check({name, " code"}, instr_code, exp_code);
    endtask

    // ---------------- test ----------------
    initial begin
        logic [7:0] img40[40];
        img40 = '{8'h8C, 8'h01, 8'h00, 8'h00, 8'h8C, 8'h02, 8'h00, 8'h01,
                  8'h00, 8'h22, 8'h08, 8'h18, 8'h3C, 8'h02, 8'h00, 8'h0C,
                  8'h08, 8'h00, 8'h00, 8'h06, 8'hAC, 8'h03, 8'h00, 8'h04,
                  8'h10, 8'h21, 8'hFF, 8'hFE, 8'h20, 8'h42, 8'h00, 8'h01,
                  8'h14, 8'h40, 8'hFF, 8'hFD, 8'h00, 8'h00, 8'h00, 8'h0C};

        // Fetch vectors applied back-to-back once the 40-byte image is in RUN.
        vecs[0]  = '{32'd0,         32'h8C01_0000, 1'b0};
        vecs[1]  = '{32'd4,         32'h8C02_0001, 1'b0};
        vecs[2]  = '{32'd16,        32'h0800_0006, 1'b0};
        vecs[3]  = '{32'd8,         32'h0022_0818, 1'b0};
        vecs[4]  = '{32'd2,         32'h0000_0000, 1'b1};
        vecs[5]  = '{32'd12,        32'h3C02_000C, 1'b0};
        vecs[6]  = '{32'd1,         32'h0000_0000, 1'b1};
        vecs[7]  = '{32'd252,       32'h0000_0000, 1'b0};
        vecs[8]  = '{32'd256,       32'h0000_0000, 1'b1};
        vecs[9]  = '{32'd253,       32'h0000_0000, 1'b1};
        vecs[10] = '{32'h1000_0000, 32'h0000_0000, 1'b1};
        vecs[11] = '{32'd40,        32'h0000_0000, 1'b0};
        vecs[12] = '{32'd20,        32'hAC03_0004, 1'b0};
        vecs[13] = '{32'd36,        32'h0000_000C, 1'b0};

        idle_inputs();
        do_reset();

        // 1. Reset state, then a fetch in IDLE returns zeroed memory.
        check("rst code", instr_code, 32'h0);
        check("rst valid", 32'(instr_valid), 32'd0);
        check("rst fault", 32'(instr_fault), 32'd0);
        check("rst ld_count", 32'(ld_count), 32'd0);
        check("rst loaded", 32'(loaded), 32'd0);
        check("rst fetch_ready", 32'(fetch_ready), 32'd1);
        check("rst ld_ready", 32'(ld_ready), 32'd0);
        check("rst state", 32'(fsm_state), 32'd0);
        fetch_check("idle pc0", 32'd0, 32'h0, 1'b0);
        check("idle loaded", 32'(loaded), 32'd0);
        tick();
        check("idle valid drops", 32'(instr_valid), 32'd0);

        // 2. Load a 40-byte image, then table-driven fetches.
        for (int i = 0; i < 40; i++) load_buf[i] = img40[i];
        start_load();
        check("load entry state", 32'(fsm_state), 32'd1);
        check("load entry count", 32'(ld_count), 32'd0);
        send_bytes(40, 1'b1);
        check("img ld_count", 32'(ld_count), 32'd40);
        check("img loaded", 32'(loaded), 32'd1);
        check("img fetch_ready", 32'(fetch_ready), 32'd1);

        // 3. Fetch table including faults and range boundaries.
        for (int v = 0; v < 14; v++) begin
            pc        = vecs[v].pc;
            fetch_req = 1'b1;
            tick();
            check($sformatf("vec%0d valid", v), 32'(instr_valid), 32'd1);
            check($sformatf("vec%0d fault", v), 32'(instr_fault), 32'(vecs[v].fault));
            check($sformatf("vec%0d code", v), instr_code, vecs[v].code);
        end
        fetch_req = 1'b0;
        tick();
        check("hold code", instr_code, 32'h0000_000C);
        check("hold valid", 32'(instr_valid), 32'd0);
        check("hold fault", 32'(instr_fault), 32'd0);

        // Fetch coincident with ld_start: serviced, and LOAD entered.
        pc        = 32'd4;
        fetch_req = 1'b1;
        ld_start  = 1'b1;
        tick();
        ld_start = 1'b0;
        check("coinc valid", 32'(instr_valid), 32'd1);
        check("coinc code", instr_code, 32'h8C02_0001);
        check("coinc ld_ready", 32'(ld_ready), 32'd1);
        check("coinc fetch_ready", 32'(fetch_ready), 32'd0);

        // 4. fetch_req held through LOAD is dropped; first pulse follows RUN.
        pc = 32'd0;
        for (int i = 0; i < 8; i++) load_buf[i] = 8'(8'h11 * (i + 1));
        for (int i = 0; i < 8; i++) begin
            ld_valid = 1'b1;
            ld_byte  = load_buf[i];
            ld_last  = (i == 7);
            tick();
            check($sformatf("stall%0d valid", i), 32'(instr_valid), 32'd0);
            check($sformatf("stall%0d fetch_ready", i), 32'(fetch_ready), 32'(i == 7));
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("stall loaded", 32'(loaded), 32'd1);
        tick();
        check("stall first valid", 32'(instr_valid), 32'd1);
        check("stall first code", instr_code, 32'h1122_3344);
        pc = 32'd8;
        tick();
        fetch_req = 1'b0;
        check("prior bytes kept", instr_code, 32'h0022_0818);

        // 5. Full-depth load without ld_last, then restart mid-load.
        for (int i = 0; i < DEPTH_BYTES; i++) load_buf[i] = 8'(i) ^ 8'hA5;
        start_load();
        send_bytes(DEPTH_BYTES - 1, 1'b0);
        check("full-1 count", 32'(ld_count), 32'd255);
        check("full-1 loaded", 32'(loaded), 32'd0);
        ld_valid = 1'b1;
        ld_byte  = load_buf[DEPTH_BYTES - 1];
        tick();
        check("full count", 32'(ld_count), 32'(DEPTH_BYTES));
        check("full loaded", 32'(loaded), 32'd1);
        ld_byte = 8'hFF;
        tick();
        ld_valid = 1'b0;
        check("extra ignored count", 32'(ld_count), 32'(DEPTH_BYTES));
        check("extra ignored state", 32'(fsm_state), 32'd2);

        // Back-to-back fetches scored through the expected queue.
        exp_q.push_back(32'hA5A4_A7A6);
        exp_q.push_back(32'h5958_5B5A);
        fetch_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            logic [31:0] exp_word;
            pc = (k == 0) ? 32'd0 : 32'd252;
            tick();
            exp_word = exp_q.pop_front();
            check($sformatf("full word%0d", k), instr_code, exp_word);
            check($sformatf("full valid%0d", k), 32'(instr_valid), 32'd1);
        end
        fetch_req = 1'b0;

        load_buf[0] = 8'h01; load_buf[1] = 8'h02; load_buf[2] = 8'h03;
        start_load();
        send_bytes(3, 1'b0);
        check("pre-restart count", 32'(ld_count), 32'd3);
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_byte  = 8'hEE;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        check("restart count", 32'(ld_count), 32'd0);
        check("restart ld_ready", 32'(ld_ready), 32'd1);
        load_buf[0] = 8'h77;
        send_bytes(1, 1'b1);
        check("restart reload count", 32'(ld_count), 32'd1);
        fetch_check("restart word", 32'd0, 32'h7702_03A6, 1'b0);

        // 6. Reset during LOAD clears partial bytes.
        for (int i = 0; i < 6; i++) load_buf[i] = 8'(8'hC0 + i);
        start_load();
        send_bytes(6, 1'b0);
        check("midload count", 32'(ld_count), 32'd6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset state", 32'(fsm_state), 32'd0);
        check("midreset count", 32'(ld_count), 32'd0);
        check("midreset loaded", 32'(loaded), 32'd0);
        fetch_check("midreset pc4", 32'd4, 32'h0, 1'b0);
        fetch_check("midreset pc0", 32'd0, 32'h0, 1'b0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
